// File: rtl/zeroheti_pkg.sv
// Shared definitions for the machine timer: register word offsets,
// CTRL field positions and a byte-strobe merge helper.
package zeroheti_pkg;

    // Word offsets decoded from paddr_i[4:2]
    typedef enum logic [2:0] {
        MTIMER_MTIME_LO    = 3'd0,
        MTIMER_MTIME_HI    = 3'd1,
        MTIMER_MTIMECMP_LO = 3'd2,
        MTIMER_MTIMECMP_HI = 3'd3,
        MTIMER_CTRL        = 3'd4,
        MTIMER_SHADOW_HI   = 3'd5
    } mtimer_reg_e;

    localparam int unsigned MtimerCtrlEnBit = 0;
    localparam int unsigned MtimerPrescLsb  = 8;

    // Replace only the bytes of old_w whose strobe bit is set
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits one tick every presc_i+1
// enabled cycles.
// Ports: clk_i, rst_i (sync, active high), en_i (count enable),
//        presc_i (divide value), clr_i (restart count), tick_o.
module mtimer_prescaler #(
    parameter int unsigned PrescWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PrescWidth-1:0] presc_i,
    input  logic                  clr_i,
    output logic                  tick_o
);

    logic [PrescWidth-1:0] presc_cnt;
    logic                  at_limit;

    assign at_limit = (presc_cnt == presc_i);
    assign tick_o   = en_i & at_limit;

    // Disabled holds the count at 0 so enabling starts a full period
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_cnt <= '0;
        end else if (clr_i || !en_i || at_limit) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PrescWidth'(1);
        end
    end

endmodule

// File: rtl/apb_mtimer.sv
// APB3 RISC-V machine timer: 64-bit mtime/mtimecmp, prescaler, level irq.
// Ports: clk_i, rst_i (sync, active high), APB3 slave (paddr_i, psel_i,
//        penable_i, pwrite_i, pwdata_i, pstrb_i, prdata_o, pready_o,
//        pslverr_o), irq_o (registered mtime >= mtimecmp).
// Option: define APB_MTIMER_SNAPSHOT_EN to add the SHADOW_HI register,
//         loaded with mtime[63:32] whenever MTIME_LO is read.
module apb_mtimer #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned CntWidth   = 64,
    parameter int unsigned PrescWidth = 8,
    parameter int unsigned ResetPresc = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 irq_o
);

    import zeroheti_pkg::*;

    localparam int unsigned HiW = CntWidth - 32;

    mtimer_reg_e reg_idx;

    logic access;
    logic wr_en;
    logic rd_en;

    logic sel_mlo;
    logic sel_mhi;
    logic sel_clo;
    logic sel_chi;
    logic sel_ctrl;

    logic wr_mlo;
    logic wr_mhi;
    logic wr_clo;
    logic wr_chi;
    logic wr_ctrl;

    logic [CntWidth-1:0]   mtime_q;
    logic [CntWidth-1:0]   mtimecmp_q;
    logic                  en_q;
    logic [PrescWidth-1:0] presc_q;
    logic                  tick;
    logic                  irq_q;

    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_wr;
    logic [31:0] rdata;
    logic        rd_err;

    logic unused_ok;

    // ------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------
    assign reg_idx = mtimer_reg_e'(paddr_i[4:2]);

    assign access = psel_i & penable_i;
    assign wr_en  = access & pwrite_i;
    assign rd_en  = access & ~pwrite_i;

    assign sel_mlo  = (reg_idx == MTIMER_MTIME_LO);
    assign sel_mhi  = (reg_idx == MTIMER_MTIME_HI);
    assign sel_clo  = (reg_idx == MTIMER_MTIMECMP_LO);
    assign sel_chi  = (reg_idx == MTIMER_MTIMECMP_HI);
    assign sel_ctrl = (reg_idx == MTIMER_CTRL);

    assign wr_mlo  = wr_en & sel_mlo;
    assign wr_mhi  = wr_en & sel_mhi;
    assign wr_clo  = wr_en & sel_clo;
    assign wr_chi  = wr_en & sel_chi;
    assign wr_ctrl = wr_en & sel_ctrl;

    // ------------------------------------------------------------
    // CTRL register
    // ------------------------------------------------------------
    assign ctrl_rd = (32'(presc_q) << MtimerPrescLsb)
                   | (32'(en_q) << MtimerCtrlEnBit);

    assign ctrl_wr = strb_merge(ctrl_rd, pwdata_i, pstrb_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            presc_q <= PrescWidth'(ResetPresc);
        end else if (wr_ctrl) begin
            en_q    <= ctrl_wr[MtimerCtrlEnBit];
            presc_q <= ctrl_wr[MtimerPrescLsb +: PrescWidth];
        end
    end

    // ------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------
    mtimer_prescaler #(
        .PrescWidth (PrescWidth)
    ) u_presc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_q),
        .presc_i (presc_q),
        .clr_i   (wr_ctrl),
        .tick_o  (tick)
    );

    // ------------------------------------------------------------
    // mtime: a software write to either half suppresses the tick
    // for that cycle, so the unwritten half sees no carry.
    // ------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q <= '0;
        end else if (wr_mlo || wr_mhi) begin
            if (wr_mlo) begin
                mtime_q[31:0] <= strb_merge(mtime_q[31:0],
                                            pwdata_i, pstrb_i);
            end
            if (wr_mhi) begin
                mtime_q[CntWidth-1:32] <= HiW'(strb_merge(
                    32'(mtime_q[CntWidth-1:32]), pwdata_i, pstrb_i));
            end
        end else if (tick) begin
            mtime_q <= mtime_q + CntWidth'(1);
        end
    end

    // ------------------------------------------------------------
    // mtimecmp
    // ------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtimecmp_q <= '1;
        end else begin
            if (wr_clo) begin
                mtimecmp_q[31:0] <= strb_merge(mtimecmp_q[31:0],
                                               pwdata_i, pstrb_i);
            end
            if (wr_chi) begin
                mtimecmp_q[CntWidth-1:32] <= HiW'(strb_merge(
                    32'(mtimecmp_q[CntWidth-1:32]), pwdata_i, pstrb_i));
            end
        end
    end

    // ------------------------------------------------------------
    // Interrupt: registered compare of the current register values
    // ------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign irq_o = irq_q;

    // ------------------------------------------------------------
    // Optional coherent-read shadow of the high word
    // ------------------------------------------------------------
`ifdef APB_MTIMER_SNAPSHOT_EN
    logic        sel_shd;
    logic [31:0] shadow_hi_q;

    assign sel_shd = (reg_idx == MTIMER_SHADOW_HI);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_hi_q <= '0;
        end else if (rd_en && sel_mlo) begin
            shadow_hi_q <= 32'(mtime_q[CntWidth-1:32]);
        end
    end
`endif

    // ------------------------------------------------------------
    // Read mux and error decode
    // ------------------------------------------------------------
    always_comb begin
        rdata  = '0;
        rd_err = 1'b0;
        unique case (1'b1)
            sel_mlo:  rdata = mtime_q[31:0];
            sel_mhi:  rdata = 32'(mtime_q[CntWidth-1:32]);
            sel_clo:  rdata = mtimecmp_q[31:0];
            sel_chi:  rdata = 32'(mtimecmp_q[CntWidth-1:32]);
            sel_ctrl: rdata = ctrl_rd;
`ifdef APB_MTIMER_SNAPSHOT_EN
            sel_shd:  rdata = shadow_hi_q;
`endif
            default:  rd_err = 1'b1;
        endcase
    end

    assign pready_o  = access;
    assign prdata_o  = (rd_en && !rst_i) ? rdata : '0;
    assign pslverr_o = access & ~rst_i & rd_err;

    assign unused_ok = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0], ctrl_wr};

endmodule

// File: tb/tb_apb_mtimer.sv
// Directed bench for apb_mtimer: APB reads go through an expected-value
// queue that is filled at request time and drained at the access phase.
module tb_apb_mtimer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] paddr_i = '0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic [3:0]  pstrb_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        irq_o;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    apb_mtimer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .paddr_i   (paddr_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .pwdata_i  (pwdata_i),
        .pstrb_i   (pstrb_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; commits at the second following edge
    task automatic apb_write(input logic [2:0] off, input logic [31:0] d,
                             input logic [3:0] s);
        paddr_i   = {27'd0, off, 2'b00};
        pwdata_i  = d;
        pstrb_i   = s;
        pwrite_i  = 1'b1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        @(posedge clk_i);
        #1 penable_i = 1'b1;
        @(posedge clk_i);
        #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        pstrb_i   = '0;
    endtask

    task automatic apb_read(input string tag, input logic [2:0] off,
                            input logic [31:0] d, input logic e);
        exp_t x;
        sb_q.push_back('{tag, d, e});
        paddr_i   = {27'd0, off, 2'b00};
        pwrite_i  = 1'b0;
        pstrb_i   = '0;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_setup"}, 64'({pslverr_o, prdata_o}), 64'd0);
        @(posedge clk_i);
        #1 penable_i = 1'b1;
        @(negedge clk_i);
        x = sb_q.pop_front();
        check(x.tag, 64'({pslverr_o, prdata_o}), 64'({x.err, x.data}));
        check({tag, "_ready"}, 64'(pready_o), 64'd1);
        @(posedge clk_i);
        #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic shd_err;
        logic [31:0] shd_val;
`ifdef APB_MTIMER_SNAPSHOT_EN
        shd_err = 1'b0;
        shd_val = 32'd1;
`else
        shd_err = 1'b1;
        shd_val = 32'd0;
`endif

        // Reset
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("rst_irq", 64'(irq_o), 64'd0);
        apb_read("rst_mlo", 3'd0, 32'h0, 1'b0);
        apb_read("rst_mhi", 3'd1, 32'h0, 1'b0);
        apb_read("rst_clo", 3'd2, 32'hFFFF_FFFF, 1'b0);
        apb_read("rst_chi", 3'd3, 32'hFFFF_FFFF, 1'b0);
        apb_read("rst_ctrl", 3'd4, 32'h0, 1'b0);
        apb_read("rst_off5", 3'd5, 32'h0, shd_err);
        apb_read("rst_off6", 3'd6, 32'h0, 1'b1);
        check("rst_irq2", 64'(irq_o), 64'd0);

        // Error offset and byte strobes
        apb_read("off7", 3'd7, 32'h0, 1'b1);
        apb_write(3'd2, 32'hFFFF_FFFF, 4'hF);
        apb_write(3'd2, 32'hAABB_CCDD, 4'b0010);
        apb_read("strb_clo", 3'd2, 32'hFFFF_CCFF, 1'b0);
        apb_write(3'd4, 32'h0000_0501, 4'b0010);
        apb_read("strb_ctrl", 3'd4, 32'h0000_0500, 1'b0);
        apb_write(3'd4, 32'h0, 4'hF);

        // Prescaler rate: presc=3 gives one tick per 4 cycles
        apb_write(3'd4, 32'h0000_0301, 4'hF);
        idle(40);
        apb_read("presc3", 3'd0, 32'd10, 1'b0);
        apb_write(3'd4, 32'h0, 4'hF);
        apb_write(3'd0, 32'h0, 4'hF);
        apb_write(3'd1, 32'h0, 4'hF);
        apb_write(3'd4, 32'h0000_0300, 4'hF);
        idle(40);
        apb_read("presc_off", 3'd0, 32'd0, 1'b0);

        // Compare interrupt
        apb_write(3'd3, 32'h0, 4'hF);
        apb_write(3'd2, 32'd5, 4'hF);
        apb_write(3'd4, 32'h1, 4'hF);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("irq_at4", 64'(irq_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("irq_at5", 64'(irq_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("irq_rise", 64'(irq_o), 64'd1);
        @(posedge clk_i);
        #1;
        apb_write(3'd3, 32'h1, 4'hF);
        @(negedge clk_i);
        check("irq_hold", 64'(irq_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("irq_fall", 64'(irq_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Wrap at 2^64
        apb_write(3'd4, 32'h0, 4'hF);
        apb_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        apb_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        apb_write(3'd4, 32'h1, 4'hF);
        apb_read("wrap_lo", 3'd0, 32'd0, 1'b0);
        apb_read("wrap_hi", 3'd1, 32'd0, 1'b0);

        // Write colliding with a tick: no increment, no carry
        apb_write(3'd4, 32'h0, 4'hF);
        apb_write(3'd1, 32'h0, 4'hF);
        apb_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        apb_write(3'd4, 32'h0000_0301, 4'hF);
        idle(2);
        apb_write(3'd0, 32'h0000_0100, 4'hF);
        apb_read("coll_lo", 3'd0, 32'h0000_0100, 1'b0);
        apb_read("coll_hi", 3'd1, 32'h0, 1'b0);

        // Snapshot of the high word on a low-word read
        apb_write(3'd4, 32'h0, 4'hF);
        apb_write(3'd0, 32'h0, 4'hF);
        apb_write(3'd1, 32'h1, 4'hF);
        apb_write(3'd4, 32'h1, 4'hF);
        apb_write(3'd0, 32'hFFFF_FFFE, 4'hF);
        apb_read("snap_lo", 3'd0, 32'hFFFF_FFFF, 1'b0);
        idle(4);
        apb_read("snap_shd", 3'd5, shd_val, shd_err);
        apb_read("snap_mhi", 3'd1, 32'd2, 1'b0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
